// File: rtl/sw_test_status_pkg.sv
// Shared types for the SW test-status monitor: status codes written by the CPU,
// the monitor's state encoding, and small decode helpers.
package sw_test_status_pkg;

  // Codes the software writes into the status word (bits [15:0]).
  typedef enum logic [15:0] {
    UnderReset = 16'h0000,
    InBootRom  = 16'hb090,
    InTest     = 16'h4354,
    InWfi      = 16'h1d1e,
    Passed     = 16'h900d,
    Failed     = 16'hbaad
  } sw_test_status_e;

  // Monitor progress states; PASS and FAIL are terminal until reset.
  typedef enum logic [2:0] {
    RESET = 3'd0,
    BOOT  = 3'd1,
    TEST  = 3'd2,
    WFI   = 3'd3,
    PASS  = 3'd4,
    FAIL  = 3'd5
  } mon_state_e;

  // Depth of the optional decoded-code history.
  localparam int unsigned HIST_DEPTH = 4;

  // A word is a known code only if the upper half is clear and the lower half
  // matches one of the defined codes.
  function automatic logic is_known_code(input logic [31:0] word);
    if (word[31:16] != 16'h0000) return 1'b0;
    case (word[15:0])
      UnderReset, InBootRom, InTest, InWfi, Passed, Failed: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_terminal(input mon_state_e st);
    return (st == PASS) || (st == FAIL);
  endfunction

endpackage

// File: rtl/sw_test_status_mon_if.sv
// Snooped CPU write channel feeding the SW test-status monitor.
// The master drives the write; the monitor (slave) only returns ready.
interface sw_test_status_mon_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/sw_test_status_timer.sv
// Loadable saturating cycle counter used as the monitor's inactivity timer.
// expire_o is asserted in the cycle the counter sits on LIMIT-1 while enabled,
// so the owner can act on the following edge.
module sw_test_status_timer #(
  parameter int unsigned      CNT_W = 32,
  parameter logic [CNT_W-1:0] LIMIT = CNT_W'(1_000_000)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] LAST = LIMIT - CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over counting; counting stops at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sw_test_status_mon.sv
// Reader end of the SW test-status channel. Snoops CPU writes to STATUS_ADDR,
// decodes the status code, tracks test progress and raises sticky pass/fail/timeout
// flags. Optional history of decoded codes is enabled by defining
// SW_TEST_STATUS_MON_HIST_EN.
module sw_test_status_mon
  import sw_test_status_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(32'h0000_1000),
  parameter logic [31:0]       TIMEOUT_CYC = 32'd1_000_000,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  sw_test_status_mon_if.slave   wr,
  output logic [31:0]           status_o,
  output logic [2:0]            state_o,
  output logic                  test_done_o,
  output logic                  test_passed_o,
  output logic                  test_failed_o,
  output logic                  timeout_o,
  output logic                  unknown_code_o
`ifdef SW_TEST_STATUS_MON_HIST_EN
  ,
  output logic [HIST_DEPTH-1:0][15:0] hist_o,
  output logic [2:0]                  hist_cnt_o
`endif
);

  mon_state_e state_q;
  mon_state_e code_next;
  logic       ready_q;
  logic       wr_hit;
  logic       wr_live;
  logic       code_ok;
  logic       expire;
  logic       timer_en;
  logic       timer_load;

  // A status write is only decoded while the test is still in progress;
  // in PASS/FAIL it is accepted and dropped.
  assign wr_hit  = wr.wr_valid && ready_q && (wr.wr_addr == STATUS_ADDR);
  assign wr_live = wr_hit && !is_terminal(state_q);
  assign code_ok = is_known_code(wr.wr_data);

  // Timer runs in BOOT/TEST, holds in WFI. Every state change is caused by a
  // decoded write or a timeout, so clearing on those also covers state entry.
  assign timer_en   = (state_q == BOOT) || (state_q == TEST);
  assign timer_load = wr_live || expire || (state_q == RESET);

  sw_test_status_timer #(
    .CNT_W (CNT_W),
    .LIMIT (CNT_W'(TIMEOUT_CYC))
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load),
    .load_val_i ('0),
    .en_i       (timer_en),
    .expire_o   (expire)
  );

  // Target state for a known code arriving in the current (non-terminal) state.
  always_comb begin
    // NOTE: default first so every path assigns code_next and no latch is inferred.
    code_next = state_q;
    case (wr.wr_data[15:0])
      InBootRom: if (state_q == RESET) code_next = BOOT;
      InTest: begin
        if (state_q == RESET)                          code_next = FAIL;
        else if ((state_q == BOOT) || (state_q == WFI)) code_next = TEST;
      end
      InWfi:     if (state_q == TEST) code_next = WFI;
      Passed:    code_next = ((state_q == TEST) || (state_q == WFI)) ? PASS : FAIL;
      Failed:    code_next = FAIL;
      default:   ;
    endcase
  end

  // Progress FSM with registered status word, sticky flags and unknown-code pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= RESET;
      ready_q        <= 1'b0;
      status_o       <= '0;
      test_done_o    <= 1'b0;
      test_passed_o  <= 1'b0;
      test_failed_o  <= 1'b0;
      timeout_o      <= 1'b0;
      unknown_code_o <= 1'b0;
    end else begin
      ready_q        <= 1'b1;
      unknown_code_o <= 1'b0;
      if (wr_live) begin
        status_o <= wr.wr_data;
        if (!code_ok) begin
          unknown_code_o <= 1'b1;
        end else begin
          state_q <= code_next;
          if (code_next == PASS) begin
            test_done_o   <= 1'b1;
            test_passed_o <= 1'b1;
          end
          if (code_next == FAIL) begin
            test_done_o   <= 1'b1;
            test_failed_o <= 1'b1;
          end
        end
      end else if (expire) begin
        state_q       <= FAIL;
        test_done_o   <= 1'b1;
        test_failed_o <= 1'b1;
        timeout_o     <= 1'b1;
      end
    end
  end

  assign wr.wr_ready = ready_q;
  assign state_o     = state_q;

`ifdef SW_TEST_STATUS_MON_HIST_EN
  logic [HIST_DEPTH-1:0][15:0] hist_q;
  logic [2:0]                  hist_cnt_q;

  // Shift in each decoded code at entry 0; naturally frozen once terminal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: the history is a handful of flops, so it is reset like any other
    // register rather than treated as uninitialised storage.
    if (!rst_ni) begin
      hist_q     <= '0;
      hist_cnt_q <= '0;
    end else if (wr_live) begin
      hist_q <= {hist_q[HIST_DEPTH-2:0], wr.wr_data[15:0]};
      if (hist_cnt_q != 3'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + 3'd1;
    end
  end

  assign hist_o     = hist_q;
  assign hist_cnt_o = hist_cnt_q;
`endif

endmodule

// File: tb/tb_sw_test_status_mon.sv
// Self-checking bench for sw_test_status_mon: directed scenarios followed by
// randomized write streams, all compared every cycle against a timestamp-based
// behavioural model of the monitor.
module tb_sw_test_status_mon;
  import sw_test_status_pkg::*;

  localparam logic [31:0] ST_ADDR = 32'h0000_1000;
  localparam int          TMO     = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] status_o;
  logic [2:0]  state_o;
  logic        test_done_o, test_passed_o, test_failed_o, timeout_o, unknown_code_o;
`ifdef SW_TEST_STATUS_MON_HIST_EN
  logic [3:0][15:0] hist_o;
  logic [2:0]       hist_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  sw_test_status_mon_if #(.ADDR_W(32)) bus ();

  sw_test_status_mon #(
    .ADDR_W      (32),
    .STATUS_ADDR (ST_ADDR),
    .TIMEOUT_CYC (32'(TMO)),
    .CNT_W       (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .wr             (bus),
    .status_o       (status_o),
    .state_o        (state_o),
    .test_done_o    (test_done_o),
    .test_passed_o  (test_passed_o),
    .test_failed_o  (test_failed_o),
    .timeout_o      (timeout_o),
    .unknown_code_o (unknown_code_o)
`ifdef SW_TEST_STATUS_MON_HIST_EN
    ,
    .hist_o         (hist_o),
    .hist_cnt_o     (hist_cnt_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  mon_state_e  m_state;
  logic [31:0] m_status;
  logic        m_ready, m_done, m_pass, m_fail, m_to, m_unk;
  longint      cyc = 0;
  longint      last_evt = 0;
  logic [15:0] m_hist[$];
  logic [15:0] known_codes[6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_known(input logic [31:0] d);
    if (d[31:16] != 16'h0) return 1'b0;
    foreach (known_codes[i]) if (known_codes[i] == d[15:0]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    m_state = RESET; m_status = '0; m_ready = 0;
    m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_unk = 0;
    m_hist.delete();
  endtask

  // One clock edge of the model, from the inputs presented before that edge.
  task automatic model_edge(input logic v, input logic [31:0] a, input logic [31:0] d);
    bit         terminal;
    bit         hit;
    mon_state_e nxt;
    terminal = (m_state == PASS) || (m_state == FAIL);
    hit      = v && m_ready && (a == ST_ADDR) && !terminal;
    cyc++;
    m_ready = 1;
    m_unk   = 0;
    if (hit) begin
      m_status = d;
      last_evt = cyc;
      m_hist.push_front(d[15:0]);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      if (!is_known(d)) begin
        m_unk = 1;
      end else begin
        nxt = m_state;
        case (d[15:0])
          16'hb090: if (m_state == RESET) nxt = BOOT;
          16'h4354: if (m_state == RESET) nxt = FAIL; else nxt = TEST;
          16'h1d1e: if (m_state == TEST) nxt = WFI;
          16'h900d: nxt = (m_state == TEST || m_state == WFI) ? PASS : FAIL;
          16'hbaad: nxt = FAIL;
          default: ;
        endcase
        if (nxt == PASS) begin m_done = 1; m_pass = 1; end
        if (nxt == FAIL) begin m_done = 1; m_fail = 1; end
        m_state = nxt;
      end
    end else if ((m_state == BOOT || m_state == TEST) && (cyc - last_evt == TMO)) begin
      m_state = FAIL; m_done = 1; m_fail = 1; m_to = 1;
    end
  endtask

  task automatic compare_all();
    check("ready",   bus.wr_ready,   m_ready);
    check("state",   state_o,        m_state);
    check("status",  status_o,       m_status);
    check("done",    test_done_o,    m_done);
    check("passed",  test_passed_o,  m_pass);
    check("failed",  test_failed_o,  m_fail);
    check("timeout", timeout_o,      m_to);
    check("unknown", unknown_code_o, m_unk);
`ifdef SW_TEST_STATUS_MON_HIST_EN
    check("hist_cnt", hist_cnt_o, m_hist.size());
    for (int i = 0; i < 4; i++)
      check($sformatf("hist%0d", i), hist_o[i], (i < m_hist.size()) ? m_hist[i] : 16'h0);
`endif
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d);
    bus.wr_valid = v; bus.wr_addr = a; bus.wr_data = d;
    model_edge(v, a, d);
    @(posedge clk_i); #1;
    compare_all();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wr(input logic [15:0] code);
    step(1'b1, ST_ADDR, {16'h0, code});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ST_ADDR, 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    model_clear();
    compare_all();
    check("rst_state_async", state_o, 3'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int n;
    int r;
    known_codes[0] = 16'h0000; known_codes[1] = 16'hb090; known_codes[2] = 16'h4354;
    known_codes[3] = 16'h1d1e; known_codes[4] = 16'h900d; known_codes[5] = 16'hbaad;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    model_clear();
    #3;
    compare_all();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Ready rises one cycle after reset release; a write in that first cycle is not taken.
    wr(16'hb090);
    check("ready_rise", bus.wr_ready, 1'b1);

    // 1: normal pass
    wr(16'hb090); wr(16'h4354); wr(16'h900d);
    check("t1_state", state_o, 3'd4);
    check("t1_passed", test_passed_o, 1'b1);
    check("t1_failed", test_failed_o, 1'b0);
    wr(16'hbaad);
    check("t1_terminal_status", status_o, 32'h0000_900d);

    // 2: long idle in WFI does not time out
    apply_reset(); idle(1);
    wr(16'hb090); wr(16'h4354); wr(16'h1d1e); idle(2 * TMO); wr(16'h4354); wr(16'h900d);
    check("t2_state", state_o, 3'd4);
    check("t2_timeout", timeout_o, 1'b0);

    // 3: timeout exactly TMO cycles after entering BOOT
    apply_reset(); idle(1);
    wr(16'hb090);
    n = 0;
    while (state_o != 3'd5 && n < 3 * TMO) begin idle(1); n++; end
    check("t3_to_cycles", n, TMO);
    check("t3_timeout", timeout_o, 1'b1);
    // write landing in the last cycle wins
    apply_reset(); idle(1);
    wr(16'hb090); idle(TMO - 1); wr(16'h4354);
    check("t3_no_to_state", state_o, 3'd2);
    check("t3_no_to_flag", timeout_o, 1'b0);

    // 4: protocol error and unknown code
    apply_reset(); idle(1);
    wr(16'hb090); step(1'b1, ST_ADDR, 32'h0000_900d);
    check("t4_proto_fail", test_failed_o, 1'b1);
    apply_reset(); idle(1);
    wr(16'hb090); step(1'b1, ST_ADDR, 32'h0001_4354);
    check("t4_unknown", unknown_code_o, 1'b1);
    check("t4_state_kept", state_o, 3'd1);
    idle(1);
    check("t4_pulse_end", unknown_code_o, 1'b0);

    // 5: other address ignored, then reset mid-test
    apply_reset(); idle(1);
    wr(16'hb090); wr(16'h4354); step(1'b1, ST_ADDR + 32'd4, 32'h0000_baad);
    check("t5_ignored", state_o, 3'd2);
    apply_reset();
    check("t5_rst_status", status_o, 32'h0);

`ifdef SW_TEST_STATUS_MON_HIST_EN
    // 6: history keeps newest four
    idle(1);
    wr(16'hb090); wr(16'h4354); wr(16'h1d1e); wr(16'h4354); wr(16'h1d1e);
    check("t6_cnt", hist_cnt_o, 3'd4);
    check("t6_h0", hist_o[0], 16'h1d1e);
    check("t6_h3", hist_o[3], 16'h4354);
    apply_reset();
`endif

    // Randomized streams
    for (int s = 0; s < 40; s++) begin
      apply_reset();
      idle(1);
      if ($urandom_range(0, 3) != 0) wr(16'hb090);
      for (int k = 0; k < 50; k++) begin
        r = $urandom_range(0, 15);
        case (r)
          0, 1, 2, 3: wr($urandom_range(0, 1) ? 16'h4354 : 16'h1d1e);
          4:          wr(16'h900d);
          5:          if ($urandom_range(0, 2) == 0) wr(16'hbaad); else wr(16'hb090);
          6:          wr(16'h0000);
          7:          wr(16'($urandom));
          8:          step(1'b1, ST_ADDR, {16'($urandom_range(1, 16'hffff)), 16'h4354});
          9:          step(1'b1, ST_ADDR ^ (32'h1 << $urandom_range(2, 31)), 32'h0000_baad);
          10:         step(1'b0, ST_ADDR, 32'h0000_baad);
          default:    idle($urandom_range(1, TMO + 4));
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
